// File: rtl/sram_write_driver.sv
// Column write-driver controller: precharge, wordline + differential bitline drive, recover.
// Optional post-drive read-back verify is compiled in with `define SRAM_WRITE_VERIFY_EN.
module sram_write_driver #(
  parameter int COLS         = 16,
  parameter int PRECH_CYCLES = 2,
  parameter int DRIVE_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_req,
  output logic            wr_ready,
  input  logic [COLS-1:0] wr_data,
  input  logic [COLS-1:0] wr_mask,
  output logic            wr_done,
  output logic            wr_err,
  input  logic [COLS-1:0] preout,
  output logic            prech_en,
  output logic            wl_en,
  output logic [COLS-1:0] drv_en,
  output logic [COLS-1:0] bl_drv,
  output logic [COLS-1:0] blb_drv
);

  localparam int MAX_CYCLES = (PRECH_CYCLES > DRIVE_CYCLES) ? PRECH_CYCLES : DRIVE_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] PRECH_LOAD = CW'(PRECH_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LOAD = CW'(DRIVE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRECH,
    DRIVE,
`ifdef SRAM_WRITE_VERIFY_EN
    VERIFY,
`endif
    RECOVER
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [COLS-1:0] data_q;
  logic [COLS-1:0] mask_q;
  logic            accept;

  assign accept = wr_req && (state == IDLE);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = PRECH;
      PRECH:   if (cnt == '0) state_nx = DRIVE;
`ifdef SRAM_WRITE_VERIFY_EN
      DRIVE:   if (cnt == '0) state_nx = VERIFY;
      VERIFY:  state_nx = RECOVER;
`else
      DRIVE:   if (cnt == '0) state_nx = RECOVER;
`endif
      RECOVER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          data_q <= wr_data;
          mask_q <= wr_mask;
          cnt    <= PRECH_LOAD;
        end
        PRECH:   cnt <= (cnt == '0) ? DRIVE_LOAD : cnt - 1'b1;
        DRIVE:   if (cnt != '0) cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef SRAM_WRITE_VERIFY_EN
  logic err_q;

  // Sticky mismatch flag: captured as VERIFY ends, cleared by the next accepted request.
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (accept)
      err_q <= 1'b0;
    else if (state == VERIFY)
      err_q <= |((preout ^ data_q) & mask_q);
  end

  assign wr_err = err_q;
`else
  logic unused_preout;
  assign unused_preout = ^preout;
  assign wr_err        = 1'b0;
`endif

  always_comb begin
    wr_ready = 1'b0;
    wr_done  = 1'b0;
    prech_en = 1'b0;
    wl_en    = 1'b0;
    drv_en   = '0;
    bl_drv   = '0;
    blb_drv  = '0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        prech_en = 1'b1;
      end
      PRECH: prech_en = 1'b1;
      DRIVE: begin
        wl_en   = 1'b1;
        drv_en  = mask_q;
        bl_drv  = data_q & mask_q;
        blb_drv = ~data_q & mask_q;
      end
`ifdef SRAM_WRITE_VERIFY_EN
      VERIFY: wl_en = 1'b1;
`endif
      RECOVER: begin
        prech_en = 1'b1;
        wr_done  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_write_driver.sv
// Directed self-checking bench for sram_write_driver (COLS=16, P=2, D=3).
// Exercises the verify path too when SRAM_WRITE_VERIFY_EN is defined.
module tb_sram_write_driver;

  localparam int COLS = 16;
  localparam int P    = 2;
  localparam int D    = 3;
`ifdef SRAM_WRITE_VERIFY_EN
  localparam int V = 1;
`else
  localparam int V = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_req;
  logic            wr_ready;
  logic [COLS-1:0] wr_data;
  logic [COLS-1:0] wr_mask;
  logic            wr_done;
  logic            wr_err;
  logic [COLS-1:0] preout;
  logic            prech_en;
  logic            wl_en;
  logic [COLS-1:0] drv_en;
  logic [COLS-1:0] bl_drv;
  logic [COLS-1:0] blb_drv;

  int n_cmp  = 0;
  int n_fail = 0;

  sram_write_driver #(
    .COLS(COLS), .PRECH_CYCLES(P), .DRIVE_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_mask(wr_mask), .wr_done(wr_done), .wr_err(wr_err),
    .preout(preout), .prech_en(prech_en), .wl_en(wl_en), .drv_en(drv_en),
    .bl_drv(bl_drv), .blb_drv(blb_drv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_write(input logic [COLS-1:0] d, input logic [COLS-1:0] m);
    wr_data = d;
    wr_mask = m;
    wr_req  = 1'b1;
    step();
    wr_req  = 1'b0;
  endtask

  task automatic check_drive(input string tag, input logic [COLS-1:0] m,
                             input logic [COLS-1:0] bl, input logic [COLS-1:0] blb);
    check({tag, "_wl"},    32'(wl_en),    32'd1);
    check({tag, "_prech"}, 32'(prech_en), 32'd0);
    check({tag, "_drv"},   32'(drv_en),   32'(m));
    check({tag, "_bl"},    32'(bl_drv),   32'(bl));
    check({tag, "_blb"},   32'(blb_drv),  32'(blb));
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; wr_req = 1'b0; wr_data = '0; wr_mask = '0; preout = '0;
    steps(2);
    check("rst_prech",  32'(prech_en), 32'd1);
    check("rst_ready",  32'(wr_ready), 32'd1);
    check("rst_wl",     32'(wl_en),    32'd0);
    check("rst_drv",    32'(drv_en),   32'd0);
    check("rst_bl",     32'(bl_drv),   32'd0);
    check("rst_blb",    32'(blb_drv),  32'd0);
    check("rst_done",   32'(wr_done),  32'd0);
    check("rst_err",    32'(wr_err),   32'd0);
    rst = 1'b0;
    step();
    check("idle_ready", 32'(wr_ready), 32'd1);

    // Full write A5C3 / FFFF
    preout = 16'hA5C3;
    start_write(16'hA5C3, 16'hFFFF);
    for (int c = 1; c <= P; c++) begin
      check("full_prech",       32'(prech_en), 32'd1);
      check("full_prech_ready", 32'(wr_ready), 32'd0);
      check("full_prech_wl",    32'(wl_en),    32'd0);
      step();
    end
    for (int c = 1; c <= D; c++) begin
      check_drive("full", 16'hFFFF, 16'hA5C3, 16'h5A3C);
      step();
    end
    if (V == 1) begin
      check("verify_wl",    32'(wl_en),    32'd1);
      check("verify_drv",   32'(drv_en),   32'd0);
      check("verify_prech", 32'(prech_en), 32'd0);
      step();
    end
    check("full_done",     32'(wr_done),  32'd1);
    check("full_rec_prech",32'(prech_en), 32'd1);
    check("full_rec_wl",   32'(wl_en),    32'd0);
    check("full_rec_drv",  32'(drv_en),   32'd0);
    check("full_rec_ready",32'(wr_ready), 32'd0);
    check("full_err",      32'(wr_err),   32'd0);
    step();
    check("full_ready",    32'(wr_ready), 32'd1);
    check("full_done_off", 32'(wr_done),  32'd0);

    // Masked write FFFF / 00F0
    preout = 16'hFFFF;
    start_write(16'hFFFF, 16'h00F0);
    steps(P);
    check_drive("mask", 16'h00F0, 16'h00F0, 16'h0000);
    steps(D + V);
    check("mask_done", 32'(wr_done), 32'd1);
    step();

    // Zero mask still sequences and pulses done
    start_write(16'hBEEF, 16'h0000);
    steps(P);
    check_drive("zmask", 16'h0000, 16'h0000, 16'h0000);
    steps(D + V);
    check("zmask_done", 32'(wr_done), 32'd1);
    step();
    check("zmask_ready", 32'(wr_ready), 32'd1);

    // Held request with data changed mid-operation
    preout  = 16'h1111;
    wr_data = 16'h1111; wr_mask = 16'hFFFF; wr_req = 1'b1;
    step();
    wr_data = 16'h2222;
    steps(P);
    check_drive("hold1", 16'hFFFF, 16'h1111, 16'hEEEE);
    steps(D + V);
    check("hold1_done",  32'(wr_done),  32'd1);
    check("hold1_busy",  32'(wr_ready), 32'd0);
    step();
    check("hold_ready",  32'(wr_ready), 32'd1);
    step();
    wr_req = 1'b0;
    check("hold2_accept", 32'(wr_ready), 32'd0);
    check("hold2_prech",  32'(prech_en), 32'd1);
    steps(P);
    check_drive("hold2", 16'hFFFF, 16'h2222, 16'hDDDD);
    steps(D + V + 1);
    check("hold2_idle",  32'(wr_ready), 32'd1);

    // Reset asserted during second DRIVE cycle
    start_write(16'hCAFE, 16'hFFFF);
    steps(P + 1);
    check("abort_in_drive", 32'(wl_en), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_wl",    32'(wl_en),    32'd0);
    check("abort_drv",   32'(drv_en),   32'd0);
    check("abort_ready", 32'(wr_ready), 32'd1);
    check("abort_prech", 32'(prech_en), 32'd1);
    done_seen = (wr_done === 1'b1) ? 1 : 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (wr_done === 1'b1) done_seen = 1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

`ifdef SRAM_WRITE_VERIFY_EN
    // Mismatching read-back sets sticky error
    preout = 16'h1230;
    start_write(16'h1234, 16'hFFFF);
    steps(P + D);
    check("ver_cycle_err", 32'(wr_err), 32'd0);
    step();
    check("ver_rec_done", 32'(wr_done), 32'd1);
    check("ver_rec_err",  32'(wr_err),  32'd1);
    step();
    check("ver_idle_err", 32'(wr_err),  32'd1);
    // Matching read-back: error clears on accept and stays clear
    preout = 16'h5678;
    start_write(16'h5678, 16'hFFFF);
    check("ver_clear", 32'(wr_err), 32'd0);
    steps(P + D + 1);
    check("ver_ok_done", 32'(wr_done), 32'd1);
    check("ver_ok_err",  32'(wr_err),  32'd0);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_write_driver.md
# sram_write_driver

Column write-driver controller for the mixed-signal SRAM macro: the write-side counterpart of the column sense amplifiers. It accepts one masked word per request, sequences bitline precharge, wordline enable and differential BL/BLB drive on every column, then restores precharge and signals completion. It sits between the array controller and the array's column bitlines, in parallel with the sense-amp array.

## Interface
- `COLS`, default 16: number of columns, i.e. the data and mask width.
- `PRECH_CYCLES`, default 2: cycles of precharge before drive; must be ≥1.
- `DRIVE_CYCLES`, default 3: cycles of wordline plus bitline drive; must be ≥1.

Ports:
- `clk` input, 1: single clock; all state changes on its rising edge.
- `rst` input, 1: reset; synchronous, active-high.
- `wr_req` input, 1: write request.
- `wr_ready` output, 1: block can accept a request.
- `wr_data` input, COLS: word to write; bit i goes to column i.
- `wr_mask` input, COLS: per-column write enable; 1 means drive that column.
- `wr_done` output, 1: one-cycle completion pulse.
- `wr_err` output, 1: verify mismatch flag; see Configuration.
- `preout` input, COLS: sense-amp outputs; used only for verify.
- `prech_en` output, 1: bitline precharge enable.
- `wl_en` output, 1: wordline enable for the addressed row.
- `drv_en` output, COLS: per-column driver enable.
- `bl_drv` output, COLS: BL drive value.
- `blb_drv` output, COLS: BLB drive value.

## Operation
- FSM states: IDLE, PRECH, DRIVE, VERIFY (present only with the macro), RECOVER.
- IDLE:
  - `wr_ready`=1, `prech_en`=1, all other outputs 0.
  - A handshake (`wr_req`&&`wr_ready`) at a clock edge latches `wr_data` and `wr_mask` and moves to PRECH.
- PRECH: `prech_en`=1, `wr_ready`=0. Lasts exactly PRECH_CYCLES cycles, then DRIVE.
- DRIVE:
  - `prech_en`=0, `wl_en`=1.
  - `drv_en`=latched mask.
  - For each column i with `drv_en[i]`=1: `bl_drv[i]`=data[i] and `blb_drv[i]`=~data[i]. Unmasked columns output `bl_drv`=`blb_drv`=0.
  - Lasts exactly DRIVE_CYCLES cycles, then VERIFY if compiled in, else RECOVER.
- RECOVER: one cycle. `prech_en`=1, `wl_en`=0, `drv_en`=0, `wr_done`=1. Next state is IDLE.
- Phase counter:
  - Width is $clog2(max(PRECH_CYCLES,DRIVE_CYCLES)+1).
  - Loads at each phase entry and counts down to the phase exit.
  - Never wraps.
- Requests while `wr_ready`=0 are ignored, not queued. The requester must hold `wr_req` until the handshake.
- `wr_mask`=0 still runs the full sequence with `drv_en` all 0, and `wr_done` still pulses.
- `wr_ready` asserts in the cycle after RECOVER. There is no back-to-back accept during RECOVER.
- Reset mid-operation aborts immediately:
  - State returns to IDLE and latched data/mask clear.
  - `wr_done` is not pulsed.
  - `wr_err` clears.
- `wl_en` and `prech_en` are never both 1 in the same cycle. `drv_en` is non-zero only in DRIVE.
- `wr_err` is sticky until the next accepted request or `rst`.

## Timing
- Every output is a Moore decode of registered state and latched data, with no combinational input-to-output path.
- Values in the cycle after `rst` is sampled high:
  - `prech_en`=1, `wr_ready`=1.
  - `wl_en`=0, `drv_en`=0, `bl_drv`=0, `blb_drv`=0.
  - `wr_done`=0, `wr_err`=0.
- Handshake at edge E gives this schedule:
  - PRECH occupies cycles E+1 .. E+P.
  - DRIVE occupies cycles E+P+1 .. E+P+D.
  - [VERIFY occupies one cycle.]
  - RECOVER, with `wr_done`=1, occupies one cycle.
  - `wr_ready`=1 again at cycle E+P+D+2, or E+P+D+3 with verify.

## Configuration
- Macro `SRAM_WRITE_VERIFY_EN`.
- Defined:
  - The VERIFY state exists for one cycle after DRIVE, with `wl_en`=1, `drv_en`=0 and `prech_en`=0.
  - At the end of VERIFY, `wr_err` is set if (`preout` ^ latched data) & latched mask is non-zero.
  - `wr_err` is visible from RECOVER onward.
- Undefined: VERIFY is absent, `preout` is ignored, and `wr_err` is constant 0.

## Test plan
- Reset and idle (COLS=16, P=2, D=3): after `rst` deasserts, `wr_ready`=1, `prech_en`=1, and all drive outputs are 0.
- Full write: accept `wr_data`=16'hA5C3, `wr_mask`=16'hFFFF at edge E.
  - `prech_en`=1 at E+1..E+2.
  - At E+3..E+5: `wl_en`=1, `bl_drv`=A5C3, `blb_drv`=5A3C.
  - `wr_done` pulses at E+6.
  - `wr_ready`=1 at E+7.
- Masked write: `wr_data`=16'hFFFF, `wr_mask`=16'h00F0. During DRIVE, `drv_en`=00F0, `bl_drv`=00F0, `blb_drv`=0000.
- Ignored request: hold `wr_req` high throughout a write with the data changed mid-op.
  - Only the first word is driven.
  - The second handshake occurs at the first `wr_ready` cycle.
- Reset mid-op: assert `rst` in the second DRIVE cycle.
  - Next cycle is IDLE with `wl_en`=0 and `drv_en`=0.
  - `wr_done` is never seen.
- Verify (macro defined): write 16'h1234 with full mask while `preout`=16'h1230.
  - `wr_err`=1 from RECOVER onward.
  - `wr_err` clears on the next accept.
  - A matching `preout` leaves `wr_err`=0.
